main_mem_responder: RTL and testbench

Multi-cycle main-memory responder on the far side of the cache controller's miss interface. It accepts one word request per cycle from the cache fill/write-back engine and returns read data a fixed LATENCY cycles later with a valid strobe. This lets a full cache-block fill be pipelined: eight back-to-back requests produce eight consecutive valid words. It replaces the single-cycle data memory as the backing store behind both caches.

---
 rtl/main_mem_responder.sv | 63 ++++++
 tb/tb_main_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder behind the cache miss interface.
// Reads are sampled at acceptance and shifted through a LATENCY-deep {valid, data} pipeline.
`timescale 1ns/1ps
module main_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 32768
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           data_in,
    output logic [15:0]           data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]        mem [DEPTH];
    logic [IDX_W-1:0]   word_idx;
    logic [15:0]        rd_word;
    logic               rd_accept;
    logic [LATENCY-1:0] stage_valid;
    logic [15:0]        stage_data [LATENCY];
    logic               unused_addr_bit;

    assign unused_addr_bit = addr[0];
    assign word_idx        = IDX_W'(32'(addr[ADDR_WIDTH-1:1]) % DEPTH);
    assign rd_word         = mem[word_idx];
    assign rd_accept       = enable && !wr;

    // Storage is deliberately left out of reset; only the write port is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && enable && wr) begin
            mem[word_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            // Idle cycles inject a zero-data bubble so gaps between reads are preserved.
            stage_valid[0] <= rd_accept;
            stage_data[0]  <= rd_accept ? rd_word : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    assign data_out   = stage_data[LATENCY-1];
    assign data_valid = stage_valid[LATENCY-1];
    assign busy       = |stage_valid;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a word-array model feeds a scoreboard of
// {data, due cycle} entries that a negedge monitor retires against data_valid/data_out.
`timescale 1ns/1ps
module tb_main_mem_responder;

    localparam int LATENCY    = 4;
    localparam int ADDR_WIDTH = 16;
    localparam int DEPTH      = 32768;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;

    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    bit          mon_on = 1'b0;
    logic        exp_v;
    int          t_req;
    exp_t        sb [$];
    logic [15:0] model [int];

    main_mem_responder #(
        .LATENCY(LATENCY),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wr(wr),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drives one request cycle and updates the model/scoreboard for what the DUT should do with it.
    task automatic applyStimulus(input logic en, input logic w, input logic [15:0] a,
                                 input logic [15:0] d, input logic r);
        int idx;
        @(posedge clk);
        #1;
        rst     = r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        idx     = int'((a >> 1) % DEPTH);
        if (r) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due > cyc) sb.delete(i);
            end
        end else if (en && w) begin
            model[idx] = d;
        end else if (en) begin
            sb.push_back('{model[idx], cyc + LATENCY});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            checkOutput("data_valid", {15'd0, data_valid}, {15'd0, exp_v});
            if (exp_v) begin
                checkOutput("data_out", data_out, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        idle(1);
        @(negedge clk);
        checkOutput("reset_valid", {15'd0, data_valid}, 16'h0000);
        checkOutput("reset_busy", {15'd0, busy}, 16'h0000);
        checkOutput("reset_data", data_out, 16'h0000);
        mon_on = 1'b1;

        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h5A5A, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0002, 16'h1111, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h2020, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0022, 16'h0C0C, 1'b0);

        $display("[TB] single read latency");
        idle(2);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        t_req = cyc;
        @(negedge clk);
        checkOutput("busy_req_cycle", {15'd0, busy}, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            @(negedge clk);
            checkOutput("busy_window", {15'd0, busy},
                        {15'd0, ((cyc - t_req) >= 1) && ((cyc - t_req) <= 4)});
        end

        $display("[TB] block fill");
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i), 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000, 1'b0);
        idle(LATENCY + 1);

        $display("[TB] read/write hazards");
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0002, 16'h2222, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b1, 16'h0002, 16'h3333, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        idle(LATENCY + 1);

        $display("[TB] bubbles and address bit 0");
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0);
        idle(LATENCY + 1);

        $display("[TB] top of address space");
        applyStimulus(1'b1, 1'b1, 16'hFFFE, 16'hAAAA, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        idle(LATENCY + 1);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput("busy_before_rst", {15'd0, busy}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1);
        idle(1);
        @(negedge clk);
        checkOutput("busy_after_rst", {15'd0, busy}, 16'h0000);
        checkOutput("data_after_rst", data_out, 16'h0000);
        idle(LATENCY + 3);

        @(negedge clk);
        checkOutput("scoreboard_drained", 16'(sb.size()), 16'h0000);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
